// File: rtl/xcoord_move_ctrl.sv
// xcoord_move_ctrl: turns button/tick/respawn requests into clamped up/dw/ld strobes for the X counter
module xcoord_move_ctrl #(
  parameter logic [7:0] X_MIN    = 8'd0,
  parameter logic [7:0] X_MAX    = 8'd159,
  parameter logic [3:0] MOVE_DIV = 4'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       respawn_req,
  input  logic [7:0] spawn_x,
  input  logic [7:0] xcoord,
  output logic       up,
  output logic       dw,
  output logic       ld,
  output logic [7:0] ld_data,
  output logic       busy,
  output logic       at_left,
  output logic       at_right
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] MOVE   = 2'd3;
  logic [1:0] state_q, state_d;
  logic [3:0] move_cnt_q, move_cnt_d;
  logic [7:0] spawn_q, spawn_d, ld_data_q, ld_data_d, spawn_clamp;
  logic       pend_q, pend_d, up_q, up_d, dw_q, dw_d, ld_q, ld_d, busy_q, busy_d;
  logic       at_left_q, at_left_d, at_right_q, at_right_d;
  logic       idle, go_load, move_ok;
  always_comb begin
    spawn_clamp = spawn_x <= X_MIN ? X_MIN : spawn_x >= X_MAX ? X_MAX : spawn_x;
    spawn_d     = respawn_req ? spawn_clamp : spawn_q;
    idle        = state_q == IDLE;
    go_load     = idle && (pend_q || respawn_req);
    // a pending or fresh respawn always suppresses the move on this tick
    move_ok     = idle && frame_tick && move_cnt_q == 4'd0 && !pend_q && !respawn_req
                  && (btn_left ^ btn_right);
    up_d        = move_ok && btn_right && xcoord < X_MAX;
    dw_d        = move_ok && btn_left && xcoord > X_MIN;
    ld_d        = go_load;
    ld_data_d   = go_load ? spawn_d : 8'd0;
    busy_d      = go_load || state_q == LOAD;
    pend_d      = go_load ? 1'b0 : (pend_q || respawn_req);
    state_d     = go_load ? LOAD : (up_d || dw_d) ? MOVE : state_q == LOAD ? SETTLE : IDLE;
    move_cnt_d  = !(btn_left || btn_right) ? 4'd0
                : (up_d || dw_d) ? MOVE_DIV - 4'd1
                : (frame_tick && move_cnt_q != 4'd0) ? move_cnt_q - 4'd1 : move_cnt_q;
    at_left_d   = xcoord <= X_MIN;
    at_right_d  = xcoord >= X_MAX;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      move_cnt_q <= 4'd0;
      spawn_q    <= 8'd0;
      pend_q     <= 1'b0;
      up_q       <= 1'b0;
      dw_q       <= 1'b0;
      ld_q       <= 1'b0;
      ld_data_q  <= 8'd0;
      busy_q     <= 1'b0;
      at_left_q  <= 1'b0;
      at_right_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      move_cnt_q <= move_cnt_d;
      spawn_q    <= spawn_d;
      pend_q     <= pend_d;
      up_q       <= up_d;
      dw_q       <= dw_d;
      ld_q       <= ld_d;
      ld_data_q  <= ld_data_d;
      busy_q     <= busy_d;
      at_left_q  <= at_left_d;
      at_right_q <= at_right_d;
    end
  end
  assign up       = up_q;
  assign dw       = dw_q;
  assign ld       = ld_q;
  assign ld_data  = ld_data_q;
  assign busy     = busy_q;
  assign at_left  = at_left_q;
  assign at_right = at_right_q;
endmodule

// File: tb/tb_xcoord_move_ctrl.sv
// tb_xcoord_move_ctrl: directed vector table plus hand sequences for reset, divider and respawn corners
module tb_xcoord_move_ctrl;
  logic       clk = 1'b0, reset = 1'b0;
  logic       frame_tick = 1'b0, btn_left = 1'b0, btn_right = 1'b0, respawn_req = 1'b0;
  logic [7:0] spawn_x = 8'd0, xcoord = 8'd0;
  logic       up, dw, ld, busy, at_left, at_right;
  logic [7:0] ld_data;
  logic       up3, dw3, ld3, busy3, at_left3, at_right3;
  logic [7:0] ld_data3;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  xcoord_move_ctrl u_dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_left(btn_left),
    .btn_right(btn_right), .respawn_req(respawn_req), .spawn_x(spawn_x), .xcoord(xcoord),
    .up(up), .dw(dw), .ld(ld), .ld_data(ld_data), .busy(busy),
    .at_left(at_left), .at_right(at_right));

  xcoord_move_ctrl #(.MOVE_DIV(4'd3)) u_div3 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_left(btn_left),
    .btn_right(btn_right), .respawn_req(respawn_req), .spawn_x(spawn_x), .xcoord(xcoord),
    .up(up3), .dw(dw3), .ld(ld3), .ld_data(ld_data3), .busy(busy3),
    .at_left(at_left3), .at_right(at_right3));

  typedef struct packed {
    logic       l, r, t, rs;
    logic [7:0] sp, xc;
    logic       eu, ed, el;
    logic [7:0] edat;
    logic       eb, eal, ear;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic l, input logic r, input logic t, input logic rs,
                       input logic [7:0] sp, input logic [7:0] xc);
    btn_left = l; btn_right = r; frame_tick = t; respawn_req = rs; spawn_x = sp; xcoord = xc;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,8'd0,  8'd5,   1'b0,1'b0,1'b0,8'd0,  1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b1,1'b1,1'b0,8'd0,  8'd5,   1'b1,1'b0,1'b0,8'd0,  1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,8'd0,  8'd6,   1'b0,1'b0,1'b0,8'd0,  1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b0,1'b1,1'b0,8'd0,  8'd6,   1'b0,1'b1,1'b0,8'd0,  1'b0,1'b0,1'b0};
    tbl[4]  = '{1'b1,1'b1,1'b1,1'b0,8'd0,  8'd5,   1'b0,1'b0,1'b0,8'd0,  1'b0,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b1,1'b1,1'b0,8'd0,  8'd159, 1'b0,1'b0,1'b0,8'd0,  1'b0,1'b0,1'b1};
    tbl[6]  = '{1'b1,1'b0,1'b1,1'b0,8'd0,  8'd0,   1'b0,1'b0,1'b0,8'd0,  1'b0,1'b1,1'b0};
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b1,8'd200,8'd0,   1'b0,1'b0,1'b1,8'd159,1'b1,1'b1,1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,8'd0,  8'd159, 1'b0,1'b0,1'b0,8'd0,  1'b1,1'b0,1'b1};
    tbl[9]  = '{1'b0,1'b1,1'b1,1'b0,8'd0,  8'd100, 1'b0,1'b0,1'b0,8'd0,  1'b0,1'b0,1'b0};
    tbl[10] = '{1'b0,1'b1,1'b1,1'b0,8'd0,  8'd100, 1'b1,1'b0,1'b0,8'd0,  1'b0,1'b0,1'b0};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b0,8'd0,  8'd100, 1'b0,1'b0,1'b0,8'd0,  1'b0,1'b0,1'b0};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b1,8'd42, 8'd100, 1'b0,1'b0,1'b1,8'd42, 1'b1,1'b0,1'b0};
    tbl[13] = '{1'b0,1'b0,1'b0,1'b1,8'd7,  8'd100, 1'b0,1'b0,1'b0,8'd0,  1'b1,1'b0,1'b0};
    tbl[14] = '{1'b0,1'b0,1'b0,1'b0,8'd0,  8'd100, 1'b0,1'b0,1'b0,8'd0,  1'b0,1'b0,1'b0};
    tbl[15] = '{1'b0,1'b0,1'b0,1'b0,8'd0,  8'd100, 1'b0,1'b0,1'b1,8'd7,  1'b1,1'b0,1'b0};
    tbl[16] = '{1'b0,1'b0,1'b0,1'b0,8'd0,  8'd100, 1'b0,1'b0,1'b0,8'd0,  1'b1,1'b0,1'b0};
    tbl[17] = '{1'b0,1'b0,1'b0,1'b0,8'd0,  8'd100, 1'b0,1'b0,1'b0,8'd0,  1'b0,1'b0,1'b0};
    tbl[18] = '{1'b0,1'b1,1'b1,1'b1,8'd80, 8'd50,  1'b0,1'b0,1'b1,8'd80, 1'b1,1'b0,1'b0};
    tbl[19] = '{1'b0,1'b1,1'b1,1'b0,8'd0,  8'd50,  1'b0,1'b0,1'b0,8'd0,  1'b1,1'b0,1'b0};
    tbl[20] = '{1'b0,1'b1,1'b1,1'b0,8'd0,  8'd50,  1'b0,1'b0,1'b0,8'd0,  1'b0,1'b0,1'b0};
    tbl[21] = '{1'b0,1'b1,1'b1,1'b0,8'd0,  8'd80,  1'b1,1'b0,1'b0,8'd0,  1'b0,1'b0,1'b0};

    #12;
    chk("reset_outputs", {up, dw, ld, ld_data, busy, at_left, at_right}, 32'd0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].l, tbl[i].r, tbl[i].t, tbl[i].rs, tbl[i].sp, tbl[i].xc);
      step();
      chk($sformatf("vec%0d", i), {up, dw, ld, ld_data, busy, at_left, at_right},
          {tbl[i].eu, tbl[i].ed, tbl[i].el, tbl[i].edat, tbl[i].eb, tbl[i].eal, tbl[i].ear});
    end

    drive(0, 0, 0, 0, 0, 50);
    repeat (3) step();
    for (int t = 1; t <= 3; t++) begin
      drive(1, 1, 1, 0, 0, 50);
      step();
      chk($sformatf("both_held_%0d", t), {up, dw, up3, dw3}, 32'd0);
      drive(1, 1, 0, 0, 0, 50);
      step();
    end
    drive(0, 0, 0, 0, 0, 50);
    step();
    for (int t = 1; t <= 8; t++) begin
      drive(1, 0, 1, 0, 0, 50);
      step();
      chk($sformatf("div3_tick%0d", t), {up3, dw3}, {1'b0, (t == 1 || t == 4 || t == 7)});
      chk($sformatf("div1_tick%0d", t), {up, dw}, 32'd1);
      drive(1, 0, 0, 0, 0, 50);
      step();
      chk($sformatf("div3_gap%0d", t), {up3, dw3}, 32'd0);
    end

    drive(0, 0, 0, 0, 0, 50);
    repeat (2) step();
    drive(0, 0, 0, 1, 8'd33, 50);
    step();
    chk("pre_reset_ld", {ld, ld_data, busy}, {1'b1, 8'd33, 1'b1});
    drive(0, 0, 0, 0, 0, 5);
    #2 reset = 1'b0;
    #1;
    chk("async_reset", {up, dw, ld, ld_data, busy, at_left, at_right}, 32'd0);
    #2 reset = 1'b1;
    drive(0, 1, 1, 0, 0, 5);
    step();
    chk("post_reset_move", {up, dw, ld, busy}, 32'b1000);
    drive(0, 0, 0, 0, 0, 5);
    step();
    chk("post_reset_quiet", {up, dw, ld, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
